lcd_scan_driver: RTL and testbench
==================================

LCD_SCAN_DRIVER -- requirements
Module: lcd_scan_driver

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 256, meaning visible pixels per line.
REQ-002 SHALL provide parameters H_FP, H_SYNC, H_BP, defaults 16, 32, 48, meaning horizontal front porch, sync and back porch widths in pixels.
REQ-003 SHALL provide parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 240, 4, 3, 15, meaning vertical active, front porch, sync and back porch widths in lines.
REQ-004 SHALL provide parameter H_POL / V_POL, default 0 / 0, meaning sync active level (1 = active-high).
REQ-005 SHALL provide parameter CLK_DIV, default 4, meaning clk cycles per pixel; must be even and at least 2.
REQ-006 SHALL provide parameter OUT_BITS, default 4, meaning bits per colour channel (range 4..8).
REQ-007 SHALL provide parameter BORDER_RGB, default 15'h0000, meaning BGR555 colour driven while border is high.
REQ-008 SHALL provide parameter CW, default 11, meaning width of the counters and of pix_x/pix_y.
REQ-009 clk  in  1  sole clock.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 pixel  in  15  BGR555 source pixel: {b[14:10], g[9:5], r[4:0]}.
REQ-012 border  in  1  replaces pixel with BORDER_RGB.
REQ-013 test_mode  in  1  colour-bar generator enable.
REQ-014 pix_req  out  1  pixel is sampled at this clk edge.
REQ-015 pix_x / pix_y  out  CW  coordinates of the requested pixel.
REQ-016 frame_start  out  1  one-clk pulse at the first pixel request of each frame.
REQ-017 tft_clk  out  1  panel pixel clock.
REQ-018 tft_h / tft_v / tft_de  out  1  horizontal sync, vertical sync, data enable.
REQ-019 tft_r / tft_g / tft_b  out  OUT_BITS  colour channels.

Function
REQ-020 Divider div SHALL count 0..CLK_DIV-1, wrap to 0; ce = (div == CLK_DIV-1); tft_clk = (div >= CLK_DIV/2), registered.
REQ-021 hc SHALL count 0..H_TOTAL-1 on ce (H_TOTAL = sum of H_*), wrap to 0; vc SHALL increment on the hc wrap, count 0..V_TOTAL-1, and wrap to 0.
REQ-022 Line order SHALL be active [0, H_ACTIVE), then FP, SYNC, BP; the vertical axis uses the same order.
REQ-023 pix_req SHALL equal ce & (hc < H_ACTIVE) & (vc < V_ACTIVE); pix_x = hc, pix_y = vc whenever pix_req is high.
REQ-024 On every ce edge, all panel outputs SHALL register from the current hc/vc and pixel, so they lag the counters by exactly one pixel period and stay mutually aligned.
REQ-025 tft_h SHALL be asserted (level H_POL) while hc is in the SYNC interval, else ~H_POL; tft_v is the same rule on vc with V_POL.
REQ-026 tft_de SHALL be 1 iff the pixel is active.
REQ-027 Colour priority per active pixel SHALL be: test bars if test_latched; else BORDER_RGB if border; else pixel; while inactive, rgb SHALL be 0.
REQ-028 5-to-OUT_BITS expansion SHALL be c[4:0] followed by c[4:10-OUT_BITS] for OUT_BITS > 5, and c[4:5-OUT_BITS] for OUT_BITS <= 5.
REQ-029 Test bars SHALL have index = hc*8/H_ACTIVE; colours 0..7 = white, yellow, cyan, green, magenta, red, blue, black; channel values are all-ones or zero.
REQ-030 test_latched SHALL sample test_mode only on the ce where hc = 0 and vc = 0, so there is no mid-frame switch.
REQ-031 frame_start SHALL equal pix_req & (hc == 0) & (vc == 0).

Reset
REQ-032 While reset is high, div, hc and vc SHALL be 0 and test_latched 0; tft_clk, tft_de, rgb, pix_req and frame_start SHALL be 0; tft_h SHALL be ~H_POL and tft_v ~V_POL.
REQ-033 Reset asserted mid-frame SHALL take effect on the next clk edge, and the first ce after release SHALL occur CLK_DIV cycles after release, with frame_start asserted.

Verification (bench params: H 4/1/2/1, V 3/1/1/1, CLK_DIV = 2, OUT_BITS = 4; frame = 96 clk)
REQ-034 Release reset, pixel = 15'h7FFF -> frame_start at clk 2 and again at clk 98; pix_req 12 times per frame; tft_de high 4 px/line on 3 lines; rgb = 4'hF.
REQ-035 Sync check with H_POL = 0 -> tft_h low for exactly 4 clk per line, starting one pixel after hc = 5; tft_v low for exactly one full line (16 clk) per frame.
REQ-036 border = 1, BORDER_RGB = 15'h001F -> tft_r = F, tft_g = 0, tft_b = 0 on active pixels; 0 elsewhere.
REQ-037 Raise test_mode mid-frame -> bars appear only after the next frame_start; with OUT_BITS = 8, pixel = 15'h0011 -> r = 8'h8C.
REQ-038 Assert reset for 1 clk at hc = 6, vc = 2 -> all outputs at reset values next clk; the frame restarts at hc = 0, vc = 0.

Source files
------------

// File: rtl/lcd_scan_driver_if.sv
// Pixel-source and TFT-panel signals of lcd_scan_driver.
// The driver is the master; the pixel source / panel side is the slave.
interface lcd_scan_driver_if #(
    parameter int unsigned CW       = 11,
    parameter int unsigned OUT_BITS = 4
) ();
    logic [14:0]         pixel;
    logic                border;
    logic                test_mode;
    logic                pix_req;
    logic [CW-1:0]       pix_x;
    logic [CW-1:0]       pix_y;
    logic                frame_start;
    logic                tft_clk;
    logic                tft_h;
    logic                tft_v;
    logic                tft_de;
    logic [OUT_BITS-1:0] tft_r;
    logic [OUT_BITS-1:0] tft_g;
    logic [OUT_BITS-1:0] tft_b;

    modport master (
        input  pixel, border, test_mode,
        output pix_req, pix_x, pix_y, frame_start,
        output tft_clk, tft_h, tft_v, tft_de, tft_r, tft_g, tft_b
    );

    modport slave (
        output pixel, border, test_mode,
        input  pix_req, pix_x, pix_y, frame_start,
        input  tft_clk, tft_h, tft_v, tft_de, tft_r, tft_g, tft_b
    );
endinterface

// File: rtl/lcd_scan_driver.sv
// Raster scan timing generator for a parallel-RGB TFT panel: pixel clock divider,
// h/v counters, pixel fetch requests, sync/DE generation and colour formatting.
module lcd_scan_driver #(
    parameter int unsigned H_ACTIVE   = 256,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 32,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 240,
    parameter int unsigned V_FP       = 4,
    parameter int unsigned V_SYNC     = 3,
    parameter int unsigned V_BP       = 15,
    parameter bit          H_POL      = 1'b0,
    parameter bit          V_POL      = 1'b0,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned OUT_BITS   = 4,
    parameter logic [14:0] BORDER_RGB = 15'h0000,
    parameter int unsigned CW         = 11
) (
    input  logic              clk,
    input  logic              reset,
    lcd_scan_driver_if.master bus
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV / 2);
    localparam logic [CW-1:0]    H_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0]    H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0]    H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0]    H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]    V_ACT      = CW'(V_ACTIVE);
    localparam logic [CW-1:0]    V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0]    V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0]    V_LAST     = CW'(V_TOTAL - 1);

    logic [DIV_W-1:0]    div, div_nxt;
    logic [CW-1:0]       hc, hc_nxt;
    logic [CW-1:0]       vc, vc_nxt;
    logic                ce;
    logic                first_px;
    logic                active;
    logic                test_latched, test_nxt, test_eff;
    logic                tft_clk_nxt, h_nxt, v_nxt;
    logic [2:0]          bar;
    logic [14:0]         src;
    logic [OUT_BITS-1:0] r_nxt, g_nxt, b_nxt;

    // 5-bit channel widened by repeating its MSBs, or truncated to its MSBs
    function automatic logic [OUT_BITS-1:0] expand(input logic [4:0] c);
        logic [9:0] dbl;
        dbl = {c, c};
        return dbl[9 -: OUT_BITS];
    endfunction

    assign ce       = (div == DIV_LAST) && !reset;
    assign first_px = (hc == '0) && (vc == '0);
    assign active   = (hc < H_ACT) && (vc < V_ACT);

    assign bus.pix_req     = ce && active;
    assign bus.frame_start = ce && active && first_px;
    assign bus.pix_x       = hc;
    assign bus.pix_y       = vc;

    // Divider and raster counters
    always_comb begin
        div_nxt  = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        hc_nxt   = hc;
        vc_nxt   = vc;
        test_nxt = test_latched;
        if (ce) begin
            if (hc == H_LAST) begin
                hc_nxt = '0;
                vc_nxt = (vc == V_LAST) ? '0 : vc + CW'(1);
            end else begin
                hc_nxt = hc + CW'(1);
            end
            if (first_px) test_nxt = bus.test_mode;
        end
        tft_clk_nxt = (div_nxt >= DIV_HALF);
    end

    // Panel output values for the pixel at the current hc/vc.
    // The first pixel of a frame already uses the freshly sampled test_mode.
    always_comb begin
        test_eff = first_px ? bus.test_mode : test_latched;
        bar      = 3'((32'(hc) * 32'd8) / H_ACTIVE);
        src      = bus.border ? BORDER_RGB : bus.pixel;
        h_nxt    = (hc >= H_SYNC_BEG && hc < H_SYNC_END) ? H_POL : ~H_POL;
        v_nxt    = (vc >= V_SYNC_BEG && vc < V_SYNC_END) ? V_POL : ~V_POL;
        r_nxt    = '0;
        g_nxt    = '0;
        b_nxt    = '0;
        if (active) begin
            if (test_eff) begin
                r_nxt = {OUT_BITS{~bar[1]}};
                g_nxt = {OUT_BITS{~bar[2]}};
                b_nxt = {OUT_BITS{~bar[0]}};
            end else begin
                r_nxt = expand(src[4:0]);
                g_nxt = expand(src[9:5]);
                b_nxt = expand(src[14:10]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div          <= '0;
            hc           <= '0;
            vc           <= '0;
            test_latched <= 1'b0;
            bus.tft_clk  <= 1'b0;
            bus.tft_h    <= ~H_POL;
            bus.tft_v    <= ~V_POL;
            bus.tft_de   <= 1'b0;
            bus.tft_r    <= '0;
            bus.tft_g    <= '0;
            bus.tft_b    <= '0;
        end else begin
            div          <= div_nxt;
            hc           <= hc_nxt;
            vc           <= vc_nxt;
            test_latched <= test_nxt;
            bus.tft_clk  <= tft_clk_nxt;
            if (ce) begin
                bus.tft_h  <= h_nxt;
                bus.tft_v  <= v_nxt;
                bus.tft_de <= active;
                bus.tft_r  <= r_nxt;
                bus.tft_g  <= g_nxt;
                bus.tft_b  <= b_nxt;
            end
        end
    end
endmodule

// File: tb/tb_lcd_scan_driver.sv
// Self-checking bench for lcd_scan_driver: two instances (4- and 8-bit colour) compared
// against a time-based reference model of the raster.
module tb_lcd_scan_driver;
    localparam int unsigned HA = 4, HFP = 1, HS = 2, HBP = 1;
    localparam int unsigned VA = 3, VFP = 1, VS = 1, VBP = 1;
    localparam int unsigned CD = 2, CW = 11;
    localparam int unsigned HT = HA + HFP + HS + HBP;
    localparam int unsigned VT = VA + VFP + VS + VBP;
    localparam int unsigned FRAME = HT * VT * CD;
    localparam bit          H_POL = 1'b0, V_POL = 1'b0;
    localparam logic [14:0] BORDER = 15'h001F;
    // bar colours 0..7: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0]  BAR_R = 8'h33, BAR_G = 8'h0F, BAR_B = 8'h55;
    localparam logic [27:0] RST_PANEL = 28'h6000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] pixel = '0;
    logic        border = 1'b0;
    logic        test_mode = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lcd_scan_driver_if #(.CW(CW), .OUT_BITS(4)) bus4 ();
    lcd_scan_driver_if #(.CW(CW), .OUT_BITS(8)) bus8 ();

    assign bus4.pixel = pixel;
    assign bus4.border = border;
    assign bus4.test_mode = test_mode;
    assign bus8.pixel = pixel;
    assign bus8.border = border;
    assign bus8.test_mode = test_mode;

    lcd_scan_driver #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_POL(H_POL), .V_POL(V_POL), .CLK_DIV(CD), .OUT_BITS(4),
        .BORDER_RGB(BORDER), .CW(CW)
    ) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    lcd_scan_driver #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_POL(H_POL), .V_POL(V_POL), .CLK_DIV(CD), .OUT_BITS(8),
        .BORDER_RGB(BORDER), .CW(CW)
    ) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    // ---------------- reference model ----------------
    // k = clk edges since reset release; pixel period = k / CD, position follows from it.
    int unsigned k = 0;
    int unsigned mp, mh, mv;
    bit          m_h = 1'b1, m_v = 1'b1, m_de = 1'b0, m_tclk = 1'b0, m_lat = 1'b0;
    logic [23:0] m_rgb4 = '0, m_rgb8 = '0;

    function automatic int unsigned exp_ch(input logic [4:0] c, input int unsigned ob);
        int unsigned cv;
        cv = c;
        if (ob > 5) return (cv << (ob - 5)) | (cv >> (10 - ob));
        return cv >> (5 - ob);
    endfunction

    function automatic logic [23:0] colour(input int unsigned hc, input bit de, input bit lat,
                                           input bit brd, input logic [14:0] px, input int unsigned ob);
        int unsigned full, idx, r, g, b;
        logic [14:0] s;
        full = (32'd1 << ob) - 32'd1;
        r = 0; g = 0; b = 0;
        if (de) begin
            if (lat) begin
                idx = hc * 8 / HA;
                r = BAR_R[idx[2:0]] ? full : 32'd0;
                g = BAR_G[idx[2:0]] ? full : 32'd0;
                b = BAR_B[idx[2:0]] ? full : 32'd0;
            end else begin
                s = brd ? BORDER : px;
                r = exp_ch(s[4:0], ob);
                g = exp_ch(s[9:5], ob);
                b = exp_ch(s[14:10], ob);
            end
        end
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    function automatic logic [2*CW+1:0] comb_exp(input int unsigned kk);
        int unsigned p, h, v;
        p = kk / CD;
        h = p % HT;
        v = (p / HT) % VT;
        if (!((kk % CD) == CD - 1 && h < HA && v < VA)) return '0;
        return {1'b1, (h == 0 && v == 0), CW'(h), CW'(v)};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            k = 0; m_h = ~H_POL; m_v = ~V_POL; m_de = 1'b0; m_tclk = 1'b0; m_lat = 1'b0;
            m_rgb4 = '0; m_rgb8 = '0;
        end else begin
            if ((k % CD) == CD - 1) begin
                mp = k / CD;
                mh = mp % HT;
                mv = (mp / HT) % VT;
                if (mh == 0 && mv == 0) m_lat = test_mode;
                m_de = (mh < HA) && (mv < VA);
                m_h = (mh >= HA + HFP && mh < HA + HFP + HS) ? H_POL : ~H_POL;
                m_v = (mv >= VA + VFP && mv < VA + VFP + VS) ? V_POL : ~V_POL;
                m_rgb4 = colour(mh, m_de, m_lat, border, pixel, 4);
                m_rgb8 = colour(mh, m_de, m_lat, border, pixel, 8);
            end
            k = k + 1;
            m_tclk = (k % CD) >= CD / 2;
        end
    end

    // observation vectors
    logic [27:0]     panel4, panel8, exp_p4, exp_p8;
    logic [2*CW+1:0] comb4, comb8;
    assign panel4 = {bus4.tft_clk, bus4.tft_h, bus4.tft_v, bus4.tft_de,
                     8'(bus4.tft_r), 8'(bus4.tft_g), 8'(bus4.tft_b)};
    assign panel8 = {bus8.tft_clk, bus8.tft_h, bus8.tft_v, bus8.tft_de,
                     bus8.tft_r, bus8.tft_g, bus8.tft_b};
    assign exp_p4 = {m_tclk, m_h, m_v, m_de, m_rgb4};
    assign exp_p8 = {m_tclk, m_h, m_v, m_de, m_rgb8};
    assign comb4 = {bus4.pix_req, bus4.frame_start,
                    bus4.pix_req ? bus4.pix_x : CW'(0), bus4.pix_req ? bus4.pix_y : CW'(0)};
    assign comb8 = {bus8.pix_req, bus8.frame_start,
                    bus8.pix_req ? bus8.pix_x : CW'(0), bus8.pix_req ? bus8.pix_y : CW'(0)};

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 2;
        if ({panel4, comb4} !== {RST_PANEL, (2*CW+2)'(0)}) begin
            failures++; $display("FAIL reset4 got=%h/%h exp=%h/0", panel4, comb4, RST_PANEL);
        end
        if ({panel8, comb8} !== {RST_PANEL, (2*CW+2)'(0)}) begin
            failures++; $display("FAIL reset8 got=%h/%h exp=%h/0", panel8, comb8, RST_PANEL);
        end
    endtask

    task automatic test_scan();
        int fs_q[$];
        int req_n = 0, de_n = 0, h_n = 0, v_n = 0, first_h = -1;
        reset = 1'b0;
        pixel = 15'h7FFF;
        for (int c = 1; c <= 2 * FRAME; c++) begin
            @(negedge clk);
            checks += 3;
            if (panel4 !== exp_p4) begin failures++; $display("FAIL scan_panel4 k=%0d got=%h exp=%h", k, panel4, exp_p4); end
            if (panel8 !== exp_p8) begin failures++; $display("FAIL scan_panel8 k=%0d got=%h exp=%h", k, panel8, exp_p8); end
            if ({comb4, comb8} !== {2{comb_exp(k)}}) begin
                failures++; $display("FAIL scan_req k=%0d got=%h/%h exp=%h", k, comb4, comb8, comb_exp(k));
            end
            if (bus4.frame_start) fs_q.push_back(c + 1);
            req_n += int'(bus4.pix_req);
            de_n += int'(bus4.tft_de);
            v_n += int'(!bus4.tft_v);
            if (!bus4.tft_h) begin h_n++; if (first_h < 0) first_h = c; end
            if (c <= FRAME && bus4.tft_de) begin
                checks++;
                if ({bus4.tft_r, bus4.tft_g, bus4.tft_b} !== 12'hFFF) begin
                    failures++; $display("FAIL white_rgb c=%0d got=%h exp=fff", c, {bus4.tft_r, bus4.tft_g, bus4.tft_b});
                end
            end
            if (c >= FRAME) pixel = 15'($urandom);
        end
        checks += 6;
        if (fs_q.size() != 2 || fs_q[0] != 2 || fs_q[1] != 98) begin
            failures++; $display("FAIL frame_start_clk got n=%0d first=%0d exp 2 and 98", fs_q.size(), (fs_q.size() > 0) ? fs_q[0] : -1);
        end
        if (req_n != 24) begin failures++; $display("FAIL pix_req_count got=%0d exp=24", req_n); end
        if (de_n != 48) begin failures++; $display("FAIL de_clk_count got=%0d exp=48", de_n); end
        if (h_n != 48) begin failures++; $display("FAIL hsync_low_clks got=%0d exp=48", h_n); end
        if (v_n != 32) begin failures++; $display("FAIL vsync_low_clks got=%0d exp=32", v_n); end
        if (first_h != 12) begin failures++; $display("FAIL hsync_first got=%0d exp=12", first_h); end
    endtask

    task automatic test_border();
        border = 1'b1;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            pixel = 15'($urandom);
            checks += 3;
            if (panel4 !== exp_p4) begin failures++; $display("FAIL border_panel4 k=%0d got=%h exp=%h", k, panel4, exp_p4); end
            if (panel8 !== exp_p8) begin failures++; $display("FAIL border_panel8 k=%0d got=%h exp=%h", k, panel8, exp_p8); end
            if ({bus4.tft_r, bus4.tft_g, bus4.tft_b, bus8.tft_r, bus8.tft_g, bus8.tft_b}
                !== (m_de ? {12'hF00, 24'hFF0000} : 36'h0)) begin
                failures++; $display("FAIL border_rgb k=%0d got=%h de=%0d", k,
                    {bus4.tft_r, bus4.tft_g, bus4.tft_b, bus8.tft_r, bus8.tft_g, bus8.tft_b}, m_de);
            end
        end
        border = 1'b0;
    endtask

    task automatic test_bars();
        logic [11:0] bar_exp [4];
        bar_exp = '{12'hFFF, 12'h0FF, 12'hF0F, 12'h00F};
        pixel = 15'h0011;
        test_mode = 1'b0;
        for (int c = 1; c <= 2 * FRAME + 8; c++) begin
            @(negedge clk);
            if (c == 40) test_mode = 1'b1;
            if (c == FRAME + 40) test_mode = 1'b0;
            checks += 2;
            if (panel4 !== exp_p4) begin failures++; $display("FAIL bars_panel4 k=%0d got=%h exp=%h", k, panel4, exp_p4); end
            if (panel8 !== exp_p8) begin failures++; $display("FAIL bars_panel8 k=%0d got=%h exp=%h", k, panel8, exp_p8); end
            if ((c <= FRAME || c == 2 * FRAME + 2) && m_de) begin
                checks++;
                if ({bus4.tft_r, bus4.tft_g, bus4.tft_b, bus8.tft_r, bus8.tft_g, bus8.tft_b} !== {12'h800, 24'h8C0000}) begin
                    failures++; $display("FAIL no_bars c=%0d got=%h exp=8008c0000", c,
                        {bus4.tft_r, bus4.tft_g, bus4.tft_b, bus8.tft_r, bus8.tft_g, bus8.tft_b});
                end
            end
            if (c > FRAME && c <= FRAME + 8 && ((c - FRAME) % 2) == 0) begin
                checks++;
                if ({bus4.tft_r, bus4.tft_g, bus4.tft_b} !== bar_exp[(c - FRAME) / 2 - 1]) begin
                    failures++; $display("FAIL bar_colour c=%0d got=%h exp=%h", c,
                        {bus4.tft_r, bus4.tft_g, bus4.tft_b}, bar_exp[(c - FRAME) / 2 - 1]);
                end
            end
        end
        test_mode = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 1; c <= 3 * FRAME; c++) begin
            @(negedge clk);
            pixel = 15'($urandom);
            border = 1'($urandom);
            if ((c % 37) == 0) test_mode = 1'($urandom);
            checks += 3;
            if (panel4 !== exp_p4) begin failures++; $display("FAIL rand_panel4 k=%0d got=%h exp=%h", k, panel4, exp_p4); end
            if (panel8 !== exp_p8) begin failures++; $display("FAIL rand_panel8 k=%0d got=%h exp=%h", k, panel8, exp_p8); end
            if ({comb4, comb8} !== {2{comb_exp(k)}}) begin
                failures++; $display("FAIL rand_req k=%0d got=%h/%h exp=%h", k, comb4, comb8, comb_exp(k));
            end
        end
        border = 1'b0;
        test_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while ((k % FRAME) != 44 && guard < 3 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if ((k % FRAME) != 44) begin failures++; $display("FAIL reset_mid_wait got k=%0d exp k%%96=44", k); end
        reset = 1'b1;
        @(negedge clk);
        checks += 2;
        if ({panel4, comb4} !== {RST_PANEL, (2*CW+2)'(0)}) begin
            failures++; $display("FAIL reset_mid4 got=%h/%h exp=%h/0", panel4, comb4, RST_PANEL);
        end
        if ({panel8, comb8} !== {RST_PANEL, (2*CW+2)'(0)}) begin
            failures++; $display("FAIL reset_mid8 got=%h/%h exp=%h/0", panel8, comb8, RST_PANEL);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (comb4 !== {1'b1, 1'b1, CW'(0), CW'(0)}) begin
            failures++; $display("FAIL restart_fs got=%h exp=%h", comb4, {1'b1, 1'b1, CW'(0), CW'(0)});
        end
        for (int c = 2; c <= FRAME; c++) begin
            @(negedge clk);
            pixel = 15'($urandom);
            checks += 2;
            if (panel4 !== exp_p4) begin failures++; $display("FAIL restart_panel4 k=%0d got=%h exp=%h", k, panel4, exp_p4); end
            if ({comb4, comb8} !== {2{comb_exp(k)}}) begin
                failures++; $display("FAIL restart_req k=%0d got=%h/%h exp=%h", k, comb4, comb8, comb_exp(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_border();
        test_bars();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
